lkp_req_arb: RTL and testbench
==============================

LKP_REQ_ARB -- requirements
Module: lkp_req_arb

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing the A lookup port.
REQ-002 The block SHALL have parameter INFO_W, default 32, giving the lookup info width.
REQ-003 The block SHALL have parameter RSLT_W, default 16, giving the lookup result width.
REQ-004 The block SHALL have parameter ID_W, default 4, giving the tag width; the tag pool holds 2**ID_W tags.

Ports:
REQ-005 The block SHALL have ports as follows.
- clk  in  1  single clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- req_vld  in  NUM_REQ  per-requester lookup request valid.
- req_info  in  NUM_REQ*INFO_W  per-requester info; requester i uses slice i.
- req_rdy  out  NUM_REQ  per-requester accept.
- c2a_lkp_vld  out  1  lookup request valid to A.
- c2a_lkp_info  out  INFO_W  lookup info to A.
- c2a_lkp_req_id  out  ID_W  allocated tag.
- a2c_lkp_rdy  in  1  A accepts the request.
- a2c_lkp_rsp_vld  in  1  A response valid; no backpressure.
- a2c_lkp_rsp_id  in  ID_W  response tag.
- a2c_lkp_rslt  in  RSLT_W  response result.
- rsp_vld  out  NUM_REQ  one-hot response strobe to the owning requester.
- rsp_rslt  out  RSLT_W  response result, shared by all requesters.
- outstanding  out  ID_W+1  count of allocated tags.
- err_spurious  out  1  sticky flag for a response to a tag that is not allocated.

Function
REQ-006 The output stage SHALL be a single register holding vld, info, req_id and owner; it is "free" when c2a_lkp_vld=0 or a2c_lkp_rdy=1.
REQ-007 A load SHALL occur in a cycle where the stage is free, at least one req_vld bit is set, and at least one tag is free in the registered free bitmap.
REQ-008 On a load, req_rdy SHALL assert for exactly the granted requester; req_rdy is combinational and all other bits are 0.
REQ-009 Arbitration SHALL be round-robin, starting from requester rr_ptr; after a load to requester g, rr_ptr becomes (g+1) mod NUM_REQ; rr_ptr is unchanged without a load.
REQ-010 The allocated tag SHALL be the lowest-numbered free tag; on a load its free bit clears and the granted index is stored as the tag's owner.
REQ-011 A request accepted in cycle N SHALL present c2a_lkp_vld=1 with matching info and req_id in cycle N+1.
REQ-012 While c2a_lkp_vld=1 and a2c_lkp_rdy=0, c2a_lkp_vld, c2a_lkp_info and c2a_lkp_req_id SHALL hold stable.
REQ-013 When the stage is free and no load occurs, c2a_lkp_vld SHALL be 0 in the next cycle.
REQ-014 Back-to-back operation SHALL be supported: with a2c_lkp_rdy held at 1, one request issues per cycle.
REQ-015 An a2c_lkp_rsp_vld in cycle M for an allocated tag SHALL produce, in cycle M+1:
- rsp_vld one-hot at the owner index;
- rsp_rslt equal to the registered a2c_lkp_rslt;
- the tag marked free.
REQ-016 A tag freed by a cycle-M response SHALL be allocatable from cycle M+1; a load in cycle M SHALL never use a tag being freed in cycle M.
REQ-017 A response to a non-allocated tag SHALL produce no rsp_vld, SHALL leave the bitmap unchanged, and SHALL set err_spurious until reset.
REQ-018 outstanding SHALL increment on a load and decrement on a valid free; both in one cycle leaves it unchanged; its range is 0..2**ID_W.
REQ-019 With all tags allocated, no load SHALL occur; req_rdy stays 0, which exerts backpressure on every requester.
REQ-020 Responses SHALL be accepted in any tag order, independent of issue order.

Reset
REQ-021 While rst_n=0, the block SHALL drive:
- c2a_lkp_vld=0, c2a_lkp_info=0, c2a_lkp_req_id=0;
- rsp_vld=0, rsp_rslt=0;
- outstanding=0, err_spurious=0.
REQ-022 While rst_n=0, the block SHALL set rr_ptr=0 and mark all tags free.
REQ-023 Reset asserted mid-operation SHALL discard all outstanding tags and any pending output-stage request immediately (asynchronously).
REQ-024 After reset, responses to pre-reset tags SHALL be treated as spurious.

Verification
REQ-025 Arbitration and issue: req_vld=4'b1111 with a2c_lkp_rdy=1 from reset -> grants to requesters 0,1,2,3,0 in consecutive cycles, req_id 0,1,2,3,4, and outstanding reaching 5.
REQ-026 Stall: a2c_lkp_rdy=0 for 3 cycles with the stage loaded -> c2a_lkp_vld, c2a_lkp_info and c2a_lkp_req_id are unchanged, and req_rdy=0 throughout.
REQ-027 Pool exhaustion and recovery: 16 issues with no responses -> outstanding=16 and req_rdy=0; then a response with rsp_id=7 -> rsp_vld at the owner of tag 7 in the next cycle, and the next load uses req_id=7.
REQ-028 Out-of-order return: tags 0/1/2 issued to requesters 2/0/1; responses in order 2,0,1 with rslt 0xA,0xB,0xC -> rsp_vld=4'b0010 with 0xA, then 4'b0100 with 0xB, then 4'b0001 with 0xC.
REQ-029 Simultaneous load and free: a response frees tag 0 in the same cycle tag 0 is otherwise the only candidate -> no load that cycle, the load uses tag 0 the next cycle, and outstanding stays consistent.
REQ-030 Spurious response and reset: a response to a free tag 5 -> no rsp_vld and err_spurious=1; then rst_n pulsed low mid-stall -> all outputs are 0 immediately, and the first grant after reset goes to requester 0 with req_id 0.

Source files
------------

// File: rtl/lkp_req_arb_if.sv
// Signal bundle between the lookup requesters, lkp_req_arb and the A lookup engine.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface lkp_req_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned INFO_W  = 32,
    parameter int unsigned RSLT_W  = 16,
    parameter int unsigned ID_W    = 4
);
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*INFO_W-1:0] req_info;
    logic [NUM_REQ-1:0]        req_rdy;
    logic                      c2a_lkp_vld;
    logic [INFO_W-1:0]         c2a_lkp_info;
    logic [ID_W-1:0]           c2a_lkp_req_id;
    logic                      a2c_lkp_rdy;
    logic                      a2c_lkp_rsp_vld;
    logic [ID_W-1:0]           a2c_lkp_rsp_id;
    logic [RSLT_W-1:0]         a2c_lkp_rslt;
    logic [NUM_REQ-1:0]        rsp_vld;
    logic [RSLT_W-1:0]         rsp_rslt;
    logic [ID_W:0]             outstanding;
    logic                      err_spurious;

    modport slave (
        input  req_vld, req_info, a2c_lkp_rdy, a2c_lkp_rsp_vld, a2c_lkp_rsp_id, a2c_lkp_rslt,
        output req_rdy, c2a_lkp_vld, c2a_lkp_info, c2a_lkp_req_id, rsp_vld, rsp_rslt,
               outstanding, err_spurious
    );

    modport master (
        output req_vld, req_info, a2c_lkp_rdy, a2c_lkp_rsp_vld, a2c_lkp_rsp_id, a2c_lkp_rslt,
        input  req_rdy, c2a_lkp_vld, c2a_lkp_info, c2a_lkp_req_id, rsp_vld, rsp_rslt,
               outstanding, err_spurious
    );
endinterface

// File: rtl/lkp_req_arb.sv
// Round-robin arbiter sharing the A lookup port among NUM_REQ requesters, with a tag pool
// that routes out-of-order responses back to the requester that issued each lookup.
module lkp_req_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned INFO_W  = 32,
    parameter int unsigned RSLT_W  = 16,
    parameter int unsigned ID_W    = 4
) (
    input logic          clk,
    input logic          rst_n,
    lkp_req_arb_if.slave bus
);
    localparam int unsigned NUM_TAG = 1 << ID_W;
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W   = ID_W + 1;

    logic [PTR_W-1:0]   rr_ptr_q;
    logic [NUM_TAG-1:0] free_q;
    logic [PTR_W-1:0]   owner_q [NUM_TAG];
    logic               c2a_vld_q;
    logic [INFO_W-1:0]  c2a_info_q;
    logic [ID_W-1:0]    c2a_id_q;
    logic [NUM_REQ-1:0] rsp_vld_q;
    logic [RSLT_W-1:0]  rsp_rslt_q;
    logic [CNT_W-1:0]   outstanding_q;
    logic               err_q;

    logic               stage_free_c;
    logic               load_c;
    logic               rsp_ok_c;
    logic               gnt_found_c;
    logic [PTR_W-1:0]   gnt_c;
    logic [ID_W-1:0]    alloc_id_c;
    logic [NUM_TAG-1:0] alloc_mask_c;
    logic [NUM_TAG-1:0] rel_mask_c;
    logic [INFO_W-1:0]  info_arr [NUM_REQ];

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        return PTR_W'((32'(base) + off) % NUM_REQ);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_info
        assign info_arr[g] = bus.req_info[g*INFO_W +: INFO_W];
    end

    // First requesting index at or after rr_ptr, wrapping around
    always_comb begin
        gnt_c       = rr_ptr_q;
        gnt_found_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found_c && bus.req_vld[wrap_idx(rr_ptr_q, i)]) begin
                gnt_c       = wrap_idx(rr_ptr_q, i);
                gnt_found_c = 1'b1;
            end
        end
    end

    // Lowest free tag; uses the registered bitmap so a tag released this cycle is not reused yet
    always_comb begin
        alloc_id_c = '0;
        for (int t = int'(NUM_TAG) - 1; t >= 0; t--) begin
            if (free_q[ID_W'(t)]) alloc_id_c = ID_W'(t);
        end
    end

    assign stage_free_c = !c2a_vld_q || bus.a2c_lkp_rdy;
    assign load_c       = stage_free_c && gnt_found_c && (|free_q);
    assign rsp_ok_c     = bus.a2c_lkp_rsp_vld && !free_q[bus.a2c_lkp_rsp_id];
    assign alloc_mask_c = load_c ? (NUM_TAG'(1) << alloc_id_c) : '0;
    assign rel_mask_c   = rsp_ok_c ? (NUM_TAG'(1) << bus.a2c_lkp_rsp_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            free_q        <= '1;
            c2a_vld_q     <= 1'b0;
            c2a_info_q    <= '0;
            c2a_id_q      <= '0;
            rsp_vld_q     <= '0;
            rsp_rslt_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            for (int t = 0; t < int'(NUM_TAG); t++) owner_q[ID_W'(t)] <= '0;
        end else begin
            free_q    <= (free_q & ~alloc_mask_c) | rel_mask_c;
            rsp_vld_q <= rsp_ok_c ? (NUM_REQ'(1) << owner_q[bus.a2c_lkp_rsp_id]) : '0;
            if (rsp_ok_c) rsp_rslt_q <= bus.a2c_lkp_rslt;
            if (bus.a2c_lkp_rsp_vld && !rsp_ok_c) err_q <= 1'b1;

            if (load_c) begin
                rr_ptr_q            <= wrap_idx(gnt_c, 1);
                owner_q[alloc_id_c] <= gnt_c;
                c2a_vld_q           <= 1'b1;
                c2a_info_q          <= info_arr[gnt_c];
                c2a_id_q            <= alloc_id_c;
            end else if (stage_free_c) begin
                c2a_vld_q <= 1'b0;
            end

            case ({load_c, rsp_ok_c})
                2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign bus.req_rdy        = load_c ? (NUM_REQ'(1) << gnt_c) : '0;
    assign bus.c2a_lkp_vld    = c2a_vld_q;
    assign bus.c2a_lkp_info   = c2a_info_q;
    assign bus.c2a_lkp_req_id = c2a_id_q;
    assign bus.rsp_vld        = rsp_vld_q;
    assign bus.rsp_rslt       = rsp_rslt_q;
    assign bus.outstanding    = outstanding_q;
    assign bus.err_spurious   = err_q;
endmodule

// File: tb/tb_lkp_req_arb.sv
// Bench for lkp_req_arb: fixed arbitration table, directed corner sequences and a randomized
// run, all checked every cycle against a set/array based reference model.
module tb_lkp_req_arb;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned INFO_W  = 32;
    localparam int unsigned RSLT_W  = 16;
    localparam int unsigned ID_W    = 4;
    localparam int          NREQ    = 4;
    localparam int          NUM_TAG = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lkp_req_arb_if #(.NUM_REQ(NUM_REQ), .INFO_W(INFO_W), .RSLT_W(RSLT_W), .ID_W(ID_W)) bus ();

    lkp_req_arb #(.NUM_REQ(NUM_REQ), .INFO_W(INFO_W), .RSLT_W(RSLT_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: tag pool as a set of free flags plus an owner map
    bit          m_vld;
    logic [31:0] m_info;
    int          m_id;
    int          m_rr;
    bit          m_free [int];
    int          m_owner [int];
    int          m_rsp_own;
    logic [15:0] m_rslt;
    bit          m_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] req_vld;
        logic [3:0] exp_rdy;
        logic       exp_vld;
        logic [3:0] exp_id;
        logic [4:0] exp_out;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_vld     = 1'b0;
        m_info    = '0;
        m_id      = 0;
        m_rr      = 0;
        m_rsp_own = -1;
        m_rslt    = '0;
        m_err     = 1'b0;
        for (int k = 0; k < NUM_TAG; k++) begin
            m_free[k]  = 1'b1;
            m_owner[k] = 0;
        end
    endfunction

    function automatic int model_outstanding();
        int n = 0;
        for (int k = 0; k < NUM_TAG; k++) if (!m_free[k]) n++;
        return n;
    endfunction

    function automatic void model_pick(output int g, output int t);
        g = -1;
        t = -1;
        if (!m_vld || bus.a2c_lkp_rdy) begin
            for (int k = 0; k < NREQ; k++) begin
                int r = (m_rr + k) % NREQ;
                if (g < 0 && ((bus.req_vld >> r) & 4'd1) != 4'd0) g = r;
            end
            for (int k = NUM_TAG - 1; k >= 0; k--) if (m_free[k]) t = k;
        end
        if (g < 0 || t < 0) begin
            g = -1;
            t = -1;
        end
    endfunction

    function automatic void model_advance(input int g, input int t);
        int rel = -1;
        int own = -1;
        if (bus.a2c_lkp_rsp_vld) begin
            int id = int'(bus.a2c_lkp_rsp_id);
            if (m_free[id]) begin
                m_err = 1'b1;
            end else begin
                rel    = id;
                own    = m_owner[id];
                m_rslt = bus.a2c_lkp_rslt;
            end
        end
        if (g >= 0) begin
            m_free[t]  = 1'b0;
            m_owner[t] = g;
            m_rr       = (g + 1) % NREQ;
            m_vld      = 1'b1;
            m_info     = 32'(bus.req_info >> (g * 32));
            m_id       = t;
        end else if (bus.a2c_lkp_rdy) begin
            m_vld = 1'b0;
        end
        if (rel >= 0) m_free[rel] = 1'b1;
        m_rsp_own = own;
    endfunction

    task automatic drive(input logic [3:0] rv, input logic rdy, input logic rsp,
                         input logic [3:0] id, input logic [15:0] rslt);
        bus.req_vld         = rv;
        bus.a2c_lkp_rdy     = rdy;
        bus.a2c_lkp_rsp_vld = rsp;
        bus.a2c_lkp_rsp_id  = id;
        bus.a2c_lkp_rslt    = rslt;
    endtask

    // Compare every output against the model for the current cycle, then clock once
    task automatic step(input string tag);
        int g;
        int t;
        #1;
        model_pick(g, t);
        chk({tag, ".req_rdy"}, 64'(bus.req_rdy), (g < 0) ? 64'd0 : (64'd1 << g));
        chk({tag, ".c2a_vld"}, 64'(bus.c2a_lkp_vld), 64'(m_vld));
        chk({tag, ".c2a_info"}, 64'(bus.c2a_lkp_info), 64'(m_info));
        chk({tag, ".c2a_id"}, 64'(bus.c2a_lkp_req_id), 64'(m_id));
        chk({tag, ".rsp_vld"}, 64'(bus.rsp_vld), (m_rsp_own < 0) ? 64'd0 : (64'd1 << m_rsp_own));
        if (m_rsp_own >= 0) chk({tag, ".rsp_rslt"}, 64'(bus.rsp_rslt), 64'(m_rslt));
        chk({tag, ".outstanding"}, 64'(bus.outstanding), 64'(model_outstanding()));
        chk({tag, ".err"}, 64'(bus.err_spurious), 64'(m_err));
        model_advance(g, t);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        drive(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_c2a_vld"}, 64'(bus.c2a_lkp_vld), 64'd0);
        chk({tag, ".rst_c2a_info"}, 64'(bus.c2a_lkp_info), 64'd0);
        chk({tag, ".rst_c2a_id"}, 64'(bus.c2a_lkp_req_id), 64'd0);
        chk({tag, ".rst_rsp_vld"}, 64'(bus.rsp_vld), 64'd0);
        chk({tag, ".rst_rsp_rslt"}, 64'(bus.rsp_rslt), 64'd0);
        chk({tag, ".rst_outstanding"}, 64'(bus.outstanding), 64'd0);
        chk({tag, ".rst_err"}, 64'(bus.err_spurious), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0] = '{4'hF, 4'b0001, 1'b0, 4'd0, 5'd0};
        vt[1] = '{4'hF, 4'b0010, 1'b1, 4'd0, 5'd1};
        vt[2] = '{4'hF, 4'b0100, 1'b1, 4'd1, 5'd2};
        vt[3] = '{4'hF, 4'b1000, 1'b1, 4'd2, 5'd3};
        vt[4] = '{4'hF, 4'b0001, 1'b1, 4'd3, 5'd4};
        vt[5] = '{4'h0, 4'b0000, 1'b1, 4'd4, 5'd5};
        vt[6] = '{4'h0, 4'b0000, 1'b0, 4'd4, 5'd5};

        bus.req_info = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        drive(4'd0, 1'b0, 1'b0, 4'd0, 16'd0);
        #2;
        do_reset("init");

        // Round-robin issue from reset
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].req_vld, 1'b1, 1'b0, 4'd0, 16'd0);
            #1;
            chk($sformatf("arb%0d.req_rdy", i), 64'(bus.req_rdy), 64'(vt[i].exp_rdy));
            chk($sformatf("arb%0d.c2a_vld", i), 64'(bus.c2a_lkp_vld), 64'(vt[i].exp_vld));
            if (vt[i].exp_vld) chk($sformatf("arb%0d.c2a_id", i), 64'(bus.c2a_lkp_req_id), 64'(vt[i].exp_id));
            chk($sformatf("arb%0d.outstanding", i), 64'(bus.outstanding), 64'(vt[i].exp_out));
            step($sformatf("arb%0d", i));
        end

        // Response to free tag 5
        drive(4'd0, 1'b1, 1'b1, 4'd5, 16'h5555);
        step("spur0");
        drive(4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("spur.rsp_vld", 64'(bus.rsp_vld), 64'd0);
        chk("spur.err", 64'(bus.err_spurious), 64'd1);
        step("spur1");

        // Load requester 1 with tag 5, then stall three cycles
        drive(4'hF, 1'b0, 1'b0, 4'd0, 16'd0);
        #1;
        chk("stall.load_rdy", 64'(bus.req_rdy), 64'b0010);
        step("stall_load");
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, 1'b0, 1'b0, 4'd0, 16'd0);
            #1;
            chk($sformatf("stall%0d.vld", i), 64'(bus.c2a_lkp_vld), 64'd1);
            chk($sformatf("stall%0d.info", i), 64'(bus.c2a_lkp_info), 64'hBBBB_0001);
            chk($sformatf("stall%0d.id", i), 64'(bus.c2a_lkp_req_id), 64'd5);
            chk($sformatf("stall%0d.req_rdy", i), 64'(bus.req_rdy), 64'd0);
            step($sformatf("stall%0d", i));
        end

        // Reset while the stage is stalled, then first grant and a pre-reset tag response
        do_reset("mid");
        drive(4'hF, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("post.req_rdy", 64'(bus.req_rdy), 64'b0001);
        step("post0");
        drive(4'd0, 1'b1, 1'b1, 4'd3, 16'h3333);
        #1;
        chk("post.c2a_vld", 64'(bus.c2a_lkp_vld), 64'd1);
        chk("post.c2a_id", 64'(bus.c2a_lkp_req_id), 64'd0);
        chk("post.c2a_info", 64'(bus.c2a_lkp_info), 64'hAAAA_0000);
        step("post1");
        drive(4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("post.stale_rsp_vld", 64'(bus.rsp_vld), 64'd0);
        chk("post.stale_err", 64'(bus.err_spurious), 64'd1);
        step("post2");

        // Out-of-order return: tags 0/1/2 to requesters 2/0/1
        do_reset("ooo");
        drive(4'b0100, 1'b1, 1'b0, 4'd0, 16'd0);
        step("ooo_i0");
        drive(4'b0001, 1'b1, 1'b0, 4'd0, 16'd0);
        step("ooo_i1");
        drive(4'b0010, 1'b1, 1'b0, 4'd0, 16'd0);
        step("ooo_i2");
        drive(4'd0, 1'b1, 1'b1, 4'd2, 16'h000A);
        step("ooo_r0");
        drive(4'd0, 1'b1, 1'b1, 4'd0, 16'h000B);
        #1;
        chk("ooo0.rsp_vld", 64'(bus.rsp_vld), 64'b0010);
        chk("ooo0.rsp_rslt", 64'(bus.rsp_rslt), 64'h000A);
        step("ooo_r1");
        drive(4'd0, 1'b1, 1'b1, 4'd1, 16'h000C);
        #1;
        chk("ooo1.rsp_vld", 64'(bus.rsp_vld), 64'b0100);
        chk("ooo1.rsp_rslt", 64'(bus.rsp_rslt), 64'h000B);
        step("ooo_r2");
        drive(4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("ooo2.rsp_vld", 64'(bus.rsp_vld), 64'b0001);
        chk("ooo2.rsp_rslt", 64'(bus.rsp_rslt), 64'h000C);
        step("ooo_r3");

        // Pool exhaustion: rr starts at 2, so tag k belongs to requester (2+k)%4
        for (int i = 0; i < 16; i++) begin
            drive(4'hF, 1'b1, 1'b0, 4'd0, 16'd0);
            step($sformatf("fill%0d", i));
        end
        drive(4'hF, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("full.outstanding", 64'(bus.outstanding), 64'd16);
        chk("full.req_rdy", 64'(bus.req_rdy), 64'd0);
        step("full0");
        drive(4'hF, 1'b1, 1'b1, 4'd7, 16'h0077);
        #1;
        chk("full.rsp_cycle_rdy", 64'(bus.req_rdy), 64'd0);
        step("full1");
        drive(4'hF, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("recov.rsp_vld", 64'(bus.rsp_vld), 64'b0010);
        chk("recov.rsp_rslt", 64'(bus.rsp_rslt), 64'h0077);
        chk("recov.req_rdy", 64'(bus.req_rdy), 64'b0100);
        step("recov0");
        drive(4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("recov.c2a_vld", 64'(bus.c2a_lkp_vld), 64'd1);
        chk("recov.c2a_id", 64'(bus.c2a_lkp_req_id), 64'd7);
        step("recov1");

        // Free of tag 0 in the same cycle it is the only candidate
        drive(4'hF, 1'b1, 1'b1, 4'd0, 16'h00AA);
        #1;
        chk("simul.req_rdy", 64'(bus.req_rdy), 64'd0);
        chk("simul.outstanding", 64'(bus.outstanding), 64'd16);
        step("simul0");
        drive(4'hF, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("simul.next_rdy", 64'(bus.req_rdy), 64'b1000);
        chk("simul.next_out", 64'(bus.outstanding), 64'd15);
        step("simul1");
        drive(4'd0, 1'b1, 1'b0, 4'd0, 16'd0);
        #1;
        chk("simul.c2a_id", 64'(bus.c2a_lkp_req_id), 64'd0);
        chk("simul.final_out", 64'(bus.outstanding), 64'd16);
        step("simul2");

        // Randomized traffic against the model, with one reset in the middle
        do_reset("rnd");
        for (int c = 0; c < 600; c++) begin
            logic       rsp;
            logic [3:0] id;
            int         q[$];
            if (c == 300) do_reset("rnd_mid");
            bus.req_info = {$urandom, $urandom, $urandom, $urandom};
            rsp = ($urandom_range(0, 99) < 40);
            id  = 4'($urandom_range(0, 15));
            for (int k = 0; k < NUM_TAG; k++) if (!m_free[k]) q.push_back(k);
            if (q.size() > 0 && $urandom_range(0, 9) != 0) id = 4'(q[$urandom_range(0, q.size() - 1)]);
            drive(4'($urandom), ($urandom_range(0, 3) != 0), rsp, id, 16'($urandom));
            step($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
